// File: rtl/flag_spacer.sv
// ============================================================================
// flag_spacer
// ----------------------------------------------------------------------------
// Accepts single-cycle event flags and re-emits them as one-cycle FLAG_OUT
// pulses separated by at least GAP_CYCLES low cycles. Flags that arrive while
// a pulse cannot be emitted are counted in a saturating backlog (PENDING);
// a flag arriving with the backlog full and no emission is dropped and
// latches OVERFLOW. FLAG_OUT is registered so it can feed a downstream flag
// synchroniser directly.
//
// Ports
//   CLK             sole clock, rising edge
//   RESET_N         synchronous, active-low reset
//   FLAG_IN         event flag, may be high on consecutive cycles
//   ENABLE          permits emission of FLAG_OUT pulses
//   GAP_CYCLES      low cycles required after each pulse (sampled at emit)
//   CLEAR_OVERFLOW  clears OVERFLOW (a same-cycle set takes priority)
//   FLAG_OUT        registered one-cycle output flag
//   PENDING         registered count of accepted, not-yet-emitted flags
//   OVERFLOW        sticky: a flag was dropped
//   BUSY            backlog non-empty or gap countdown running
// ============================================================================
module flag_spacer #(
    parameter int CNT_WIDTH = 8,
    parameter int GAP_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 FLAG_IN,
    input  logic                 ENABLE,
    input  logic [GAP_WIDTH-1:0] GAP_CYCLES,
    input  logic                 CLEAR_OVERFLOW,
    output logic                 FLAG_OUT,
    output logic [CNT_WIDTH-1:0] PENDING,
    output logic                 OVERFLOW,
    output logic                 BUSY
);

    localparam logic [0:0]           ST_IDLE = 1'b0;
    localparam logic [0:0]           ST_GAP  = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

    logic [0:0]           state_q,    state_d;
    logic [GAP_WIDTH-1:0] gap_q,      gap_d;
    logic [CNT_WIDTH-1:0] pending_q,  pending_d;
    logic                 flag_q,     flag_d;
    logic                 overflow_q, overflow_d;
    logic                 emit;
    logic                 ovf_set;

    // An emission can consume either a backlog entry or the flag arriving in
    // the same cycle, so an empty backlog still gives single-cycle latency.
    assign emit = (state_q == ST_IDLE) && ENABLE &&
                  ((pending_q != '0) || FLAG_IN);

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        pending_d = pending_q;
        flag_d    = emit;
        ovf_set   = 1'b0;

        if (emit) begin
            // PENDING + FLAG_IN - 1: unchanged when a flag arrives, including
            // at full count, so this path can never overflow or wrap.
            if (!FLAG_IN) begin
                pending_d = pending_q - CNT_ONE;
            end
            // GAP_CYCLES is only looked at here, so later changes cannot
            // disturb a running countdown.
            if (GAP_CYCLES != '0) begin
                gap_d   = GAP_CYCLES;
                state_d = ST_GAP;
            end
        end else if (FLAG_IN) begin
            if (pending_q == CNT_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pending_d = pending_q + CNT_ONE;
            end
        end

        // The countdown runs regardless of ENABLE. Leaving on a count of one
        // puts the FSM back in IDLE after exactly G cycles in GAP, which
        // yields G low output cycles between pulses.
        if (state_q == ST_GAP) begin
            if (gap_q <= GAP_ONE) begin
                gap_d   = '0;
                state_d = ST_IDLE;
            end else begin
                gap_d = gap_q - GAP_ONE;
            end
        end

        overflow_d = ovf_set | (overflow_q & ~CLEAR_OVERFLOW);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            gap_q      <= '0;
            pending_q  <= '0;
            flag_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            flag_q     <= flag_d;
            overflow_q <= overflow_d;
        end
    end

    assign FLAG_OUT = flag_q;
    assign PENDING  = pending_q;
    assign OVERFLOW = overflow_q;
    assign BUSY     = (pending_q != '0) || (state_q == ST_GAP);

endmodule

// File: tb/tb_flag_spacer.sv
// ============================================================================
// tb_flag_spacer
// ----------------------------------------------------------------------------
// Self-checking bench for flag_spacer (CNT_WIDTH=3 so saturation is quick).
// Expected FLAG_OUT cycle numbers are queued when the stimulus is driven and
// popped by a monitor on every observed pulse; register outputs are checked
// directly against constants. Cycle n is the period that starts at the n-th
// rising clock edge; inputs are driven 1 ns after that edge.
// ============================================================================
module tb_flag_spacer;

    localparam int CW = 3;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flag_in;
    logic          enable;
    logic [GW-1:0] gap_cycles;
    logic          clear_ovf;
    logic          flag_out;
    logic [CW-1:0] pending;
    logic          overflow;
    logic          busy;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    flag_spacer #(
        .CNT_WIDTH(CW),
        .GAP_WIDTH(GW)
    ) dut (
        .CLK           (clk),
        .RESET_N       (rst_n),
        .FLAG_IN       (flag_in),
        .ENABLE        (enable),
        .GAP_CYCLES    (gap_cycles),
        .CLEAR_OVERFLOW(clear_ovf),
        .FLAG_OUT      (flag_out),
        .PENDING       (pending),
        .OVERFLOW      (overflow),
        .BUSY          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
            $display("check %-14s cyc=%0d obs=%0d exp=%0d ok", tag, cyc, obs, exp);
        end else begin
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: every observed pulse must match the oldest
    // expected pulse cycle.
    always @(negedge clk) begin
        if (flag_out) begin
            if (exp_q.size() == 0) begin
                check_val("flag_unexp", int'(flag_out), 0);
            end else begin
                check_val("flag_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    int t0;

    initial begin
        rst_n      = 1'b0;
        flag_in    = 1'b1;   // must be ignored while in reset
        enable     = 1'b1;
        gap_cycles = 8'd3;
        clear_ovf  = 1'b0;

        // ---- reset ----
        tick(3);
        check_val("rst_flag", int'(flag_out), 0);
        check_val("rst_pending", int'(pending), 0);
        check_val("rst_ovf", int'(overflow), 0);
        check_val("rst_busy", int'(busy), 0);
        flag_in = 1'b0;
        rst_n   = 1'b1;
        tick(3);
        check_val("post_rst_pend", int'(pending), 0);

        // ---- single flag, gap 3 ----
        flag_in = 1'b1;
        exp_q.push_back(cyc + 1);
        tick();
        flag_in = 1'b0;
        check_val("single_pend", int'(pending), 0);
        check_val("single_busy", int'(busy), 1);
        tick(6);

        // ---- burst of 5, gap 2: pulses every 3 cycles ----
        gap_cycles = 8'd2;
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            flag_in = 1'b1;
            exp_q.push_back(t0 + 1 + 3 * i);
            tick();
        end
        flag_in = 1'b0;
        check_val("burst_peak", int'(pending), 3);
        tick(8);                                   // cycle t0+13: last pulse
        check_val("burst_pend0", int'(pending), 0);
        tick();
        check_val("burst_busy_g", int'(busy), 1);
        tick();
        check_val("burst_busy_0", int'(busy), 0);
        tick(2);

        // ---- GAP_CYCLES change during GAP has no effect ----
        gap_cycles = 8'd4;
        t0 = cyc;
        flag_in = 1'b1;
        exp_q.push_back(t0 + 1);
        tick();
        gap_cycles = 8'd1;                         // running timer keeps 4
        exp_q.push_back(t0 + 6);
        tick();
        flag_in = 1'b0;
        check_val("gchg_pend", int'(pending), 1);
        tick(4);                                   // cycle t0+6
        check_val("gchg_busy_g", int'(busy), 1);
        tick();
        check_val("gchg_busy_0", int'(busy), 0);
        tick(2);

        // ---- countdown continues with ENABLE low ----
        gap_cycles = 8'd3;
        t0 = cyc;
        flag_in = 1'b1;
        exp_q.push_back(t0 + 1);
        tick();
        enable = 1'b0;
        tick();
        flag_in = 1'b0;
        tick(2);                                   // cycle t0+4: FSM idle
        check_val("en_off_pend", int'(pending), 1);
        enable = 1'b1;
        exp_q.push_back(t0 + 5);
        tick(6);

        // ---- zero gap: back-to-back pulses ----
        enable     = 1'b0;
        gap_cycles = 8'd0;
        flag_in    = 1'b1;
        tick(4);
        flag_in = 1'b0;
        tick();
        check_val("zg_pend4", int'(pending), 4);
        t0 = cyc;
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) exp_q.push_back(t0 + i);
        tick(3);
        check_val("zg_pend1", int'(pending), 1);
        tick();
        check_val("zg_pend0", int'(pending), 0);
        tick(2);

        // ---- saturation and overflow ----
        enable  = 1'b0;
        flag_in = 1'b1;
        tick(9);
        flag_in = 1'b0;
        check_val("sat_pend", int'(pending), 7);
        check_val("sat_ovf", int'(overflow), 1);
        flag_in   = 1'b1;                          // set and clear together
        clear_ovf = 1'b1;
        tick();
        flag_in = 1'b0;
        check_val("set_wins_ovf", int'(overflow), 1);
        check_val("set_wins_pend", int'(pending), 7);
        tick();
        clear_ovf = 1'b0;
        check_val("clear_ovf", int'(overflow), 0);

        // ---- full backlog with emit and incoming flag ----
        enable  = 1'b1;
        flag_in = 1'b1;
        exp_q.push_back(cyc + 1);
        tick();
        flag_in = 1'b0;
        enable  = 1'b0;
        check_val("full_emit_pend", int'(pending), 7);
        check_val("full_emit_ovf", int'(overflow), 0);

        // ---- reset while in GAP with backlog ----
        gap_cycles = 8'd5;
        enable     = 1'b1;
        exp_q.push_back(cyc + 1);
        tick();
        check_val("pre_rst_pend", int'(pending), 6);
        check_val("pre_rst_busy", int'(busy), 1);
        rst_n   = 1'b0;
        flag_in = 1'b1;
        tick();
        rst_n   = 1'b0;
        check_val("mid_rst_pend", int'(pending), 0);
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_flag", int'(flag_out), 0);
        rst_n   = 1'b1;
        flag_in = 1'b0;
        tick(8);                                   // no pulses expected
        check_val("idle_pend", int'(pending), 0);

        // ---- first emission after reset has one-cycle latency ----
        flag_in = 1'b1;
        exp_q.push_back(cyc + 1);
        tick();
        flag_in = 1'b0;
        tick(8);

        check_val("sb_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
